// File: rtl/obj_render_pkg.sv
// Shared definitions for the object line renderer: object entry layout,
// table geometry and the line scan state encoding.
package obj_render_pkg;

    localparam int OBJ_NUM   = 8;
    localparam int CELL_LOG2 = 5;
    localparam int ADDR_W    = 3;
    localparam int ENTRY_W   = 13;

    // Entry layout {ON, TILE, X, Y}; X and Y are in cell units.
    localparam int ON_BIT  = 12;
    localparam int TILE_HI = 11;
    localparam int TILE_LO = 9;
    localparam int X_HI    = 8;
    localparam int X_LO    = 4;
    localparam int Y_HI    = 3;
    localparam int Y_LO    = 0;

    typedef logic [ENTRY_W-1:0] obj_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    function automatic logic obj_on(input obj_entry_t e);
        return e[ON_BIT];
    endfunction

    function automatic logic [2:0] obj_tile(input obj_entry_t e);
        return e[TILE_HI:TILE_LO];
    endfunction

    function automatic logic [4:0] obj_x(input obj_entry_t e);
        return e[X_HI:X_LO];
    endfunction

    function automatic logic [3:0] obj_y(input obj_entry_t e);
        return e[Y_HI:Y_LO];
    endfunction

endpackage

// File: rtl/obj_line_scanner.sv
// Per-line scanner: walks the shadow table one entry per cycle and builds the
// mask of objects whose cell row matches the latched line.
//
// state | meaning
// IDLE  | mask holds the result of the last completed (or cleared) scan
// SCAN  | visiting entry idx; mask bits at and above idx are still pending
module obj_line_scanner
    import obj_render_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        line_start,
    input  logic [9:0]                  line_y,
    input  obj_entry_t [OBJ_NUM-1:0]    shadow,
    output logic [OBJ_NUM-1:0]          line_mask,
    output logic [CELL_LOG2-1:0]        row_off,
    output logic                        busy
);

    scan_state_t     state;
    logic [ADDR_W-1:0] idx;
    logic [9:0]      row_y;

    assign row_off = row_y[CELL_LOG2-1:0];

    // Scan FSM: a line start always (re)starts from entry 0 with a clean mask;
    // rows at or beyond y=512 never match any object.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            row_y     <= '0;
            line_mask <= '0;
            busy      <= 1'b0;
        end else if (line_start) begin
            state     <= SCAN;
            idx       <= '0;
            row_y     <= line_y;
            line_mask <= '0;
            busy      <= 1'b1;
        end else if (state == SCAN) begin
            line_mask[idx] <= obj_on(shadow[idx]) && !row_y[9]
                              && (obj_y(shadow[idx]) == row_y[CELL_LOG2 +: 4]);
            idx <= idx + 3'd1;
            if (idx == 3'(OBJ_NUM - 1)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/obj_line_renderer.sv
// Object line renderer: double-buffered 8-entry object table committed on the
// falling edge of vertical sync, a per-line scanner, and a two-stage pixel
// path reporting the highest-priority (lowest index) object under each pixel.
// Optional macro OBJREND_OVERLAP_EN builds the multi-object overlap flag;
// without it oOverlap is tied low.
module obj_line_renderer #(
    parameter int OBJ_NUM   = obj_render_pkg::OBJ_NUM,
    parameter int CELL_LOG2 = obj_render_pkg::CELL_LOG2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        iVS,
    input  logic        iLineStart,
    input  logic [9:0]  iLineY,
    input  logic [9:0]  iX,
    input  logic        iDE,
    input  logic [2:0]  iObjRam_addr,
    input  logic [12:0] iObjRam_data,
    input  logic        iObjRam_we,
    output logic        oHit,
    output logic [2:0]  oTile,
    output logic [4:0]  oOffX,
    output logic [4:0]  oOffY,
    output logic        oOverlap,
    output logic        oBusy
);

    import obj_render_pkg::*;

    obj_entry_t [OBJ_NUM-1:0] working;
    obj_entry_t [OBJ_NUM-1:0] shadow;
    logic                     last_vs;
    logic                     commit;

    logic [OBJ_NUM-1:0]       line_mask;
    logic [CELL_LOG2-1:0]     row_off;

    logic [9:0]               x_s1;
    logic                     de_s1;
    logic [CELL_LOG2-1:0]     offy_s1;

    logic [OBJ_NUM-1:0]       cand;
    logic [2:0]               win_tile;

    assign commit = last_vs && !iVS;

    // Table update: a commit copies the pre-edge working table, so a write in
    // the same cycle only reaches the shadow at the following commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            working <= '0;
            shadow  <= '0;
            last_vs <= 1'b1;
        end else begin
            last_vs <= iVS;
            if (commit)
                shadow <= working;
            if (iObjRam_we)
                working[iObjRam_addr] <= iObjRam_data;
        end
    end

    obj_line_scanner u_scanner (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (iLineStart),
        .line_y     (iLineY),
        .shadow     (shadow),
        .line_mask  (line_mask),
        .row_off    (row_off),
        .busy       (oBusy)
    );

    // Pixel stage 1: capture coordinate, enable and line offset together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_s1    <= '0;
            de_s1   <= 1'b0;
            offy_s1 <= '0;
        end else begin
            x_s1    <= iX;
            de_s1   <= iDE;
            offy_s1 <= row_off;
        end
    end

    // Candidate compare and priority encode; scanning downward lets index 0 win.
    always_comb begin
        cand     = '0;
        win_tile = '0;
        for (int i = OBJ_NUM - 1; i >= 0; i--) begin
            cand[i] = line_mask[i] && (obj_x(shadow[i]) == x_s1[9:CELL_LOG2]);
            if (cand[i])
                win_tile = obj_tile(shadow[i]);
        end
    end

    // Pixel stage 2: registered hit, tile and in-cell offsets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oHit  <= 1'b0;
            oTile <= '0;
            oOffX <= '0;
            oOffY <= '0;
        end else begin
            oHit  <= de_s1 && (|cand);
            oTile <= (de_s1 && (|cand)) ? win_tile : 3'd0;
            oOffX <= x_s1[CELL_LOG2-1:0];
            oOffY <= offy_s1;
        end
    end

`ifdef OBJREND_OVERLAP_EN
    logic [3:0] cand_cnt;

    // Count candidates for the collision overlay.
    always_comb begin
        cand_cnt = '0;
        for (int i = 0; i < OBJ_NUM; i++)
            cand_cnt = cand_cnt + {3'b000, cand[i]};
    end

    // Overlap flag registered alongside oHit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            oOverlap <= 1'b0;
        else
            oOverlap <= de_s1 && (cand_cnt > 4'd1);
    end
`else
    assign oOverlap = 1'b0;
`endif

endmodule

// File: tb/tb_obj_line_renderer.sv
// Directed self-checking bench for obj_line_renderer.
`timescale 1ns/1ps
module tb_obj_line_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iVS;
    logic        iLineStart;
    logic [9:0]  iLineY;
    logic [9:0]  iX;
    logic        iDE;
    logic [2:0]  iObjRam_addr;
    logic [12:0] iObjRam_data;
    logic        iObjRam_we;
    logic        oHit;
    logic [2:0]  oTile;
    logic [4:0]  oOffX;
    logic [4:0]  oOffY;
    logic        oOverlap;
    logic        oBusy;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_ovl;

    obj_line_renderer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .iVS          (iVS),
        .iLineStart   (iLineStart),
        .iLineY       (iLineY),
        .iX           (iX),
        .iDE          (iDE),
        .iObjRam_addr (iObjRam_addr),
        .iObjRam_data (iObjRam_data),
        .iObjRam_we   (iObjRam_we),
        .oHit         (oHit),
        .oTile        (oTile),
        .oOffX        (oOffX),
        .oOffY        (oOffY),
        .oOverlap     (oOverlap),
        .oBusy        (oBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] mk(input logic on, input logic [2:0] tile,
                                       input logic [4:0] x, input logic [3:0] y);
        return {on, tile, x, y};
    endfunction

    task automatic wr(input logic [2:0] a, input logic [12:0] d);
        iObjRam_addr = a;
        iObjRam_data = d;
        iObjRam_we   = 1'b1;
        tick();
        iObjRam_we   = 1'b0;
    endtask

    task automatic vs_fall();
        iVS = 1'b0;
        tick();
        iVS = 1'b1;
        tick();
    endtask

    task automatic scan(input logic [9:0] y);
        iLineY     = y;
        iLineStart = 1'b1;
        tick();
        iLineStart = 1'b0;
        repeat (9) tick();
    endtask

    task automatic pix(input logic [9:0] x, input logic de);
        iX  = x;
        iDE = de;
        tick();
        tick();
    endtask

    initial begin
`ifdef OBJREND_OVERLAP_EN
        exp_ovl = 1'b1;
`else
        exp_ovl = 1'b0;
`endif
        reset_n = 1'b0; iVS = 1'b1; iLineStart = 1'b0; iLineY = '0;
        iX = '0; iDE = 1'b0; iObjRam_addr = '0; iObjRam_data = '0; iObjRam_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("rst_hit",  oHit, 0);
        chk("rst_tile", oTile, 0);
        chk("rst_busy", oBusy, 0);

        // Reset in the middle of a scan
        iLineY = 10'd100; iLineStart = 1'b1;
        tick();
        iLineStart = 1'b0;
        tick(); tick();
        chk("midscan_busy", oBusy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", oBusy, 0);
        chk("midrst_mask", dut.line_mask, 0);
        chk("midrst_hit",  oHit, 0);
        chk("midrst_offy", oOffY, 0);
        chk("midrst_ovl",  oOverlap, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Basic commit, scan and pixel lookup
        wr(3'd0, mk(1'b1, 3'd0, 5'd5, 4'd3));
        wr(3'd1, mk(1'b1, 3'd1, 5'd7, 4'd3));
        vs_fall();
        iLineY = 10'd100; iLineStart = 1'b1;
        tick();
        iLineStart = 1'b0;
        chk("busy_e0", oBusy, 1);
        repeat (7) tick();
        chk("busy_e7", oBusy, 1);
        tick();
        chk("busy_e8", oBusy, 0);
        chk("mask_row3", dut.line_mask, 8'b0000_0011);
        tick();
        for (int x = 160; x < 192; x++) begin
            pix(10'(x), 1'b1);
            chk("sweep_hit",  oHit, 1);
            chk("sweep_tile", oTile, 0);
            chk("sweep_offx", oOffX, 32'(x - 160));
        end
        chk("sweep_offy", oOffY, 4);
        chk("sweep_ovl", oOverlap, 0);
        pix(10'd224, 1'b1);
        chk("x224_hit",  oHit, 1);
        chk("x224_tile", oTile, 1);
        pix(10'd200, 1'b1);
        chk("x200_hit",  oHit, 0);
        chk("x200_tile", oTile, 0);
        pix(10'd170, 1'b0);
        chk("de0_hit", oHit, 0);

        // Write without commit stays invisible until the next frame
        wr(3'd2, mk(1'b1, 3'd2, 5'd9, 4'd3));
        scan(10'd100);
        pix(10'd288, 1'b1);
        chk("nocommit_hit", oHit, 0);
        vs_fall();
        scan(10'd100);
        pix(10'd290, 1'b1);
        chk("commit_hit",  oHit, 1);
        chk("commit_tile", oTile, 2);
        chk("commit_offx", oOffX, 2);

        // Priority between two objects on the same cell
        wr(3'd1, mk(1'b1, 3'd1, 5'd5, 4'd3));
        vs_fall();
        scan(10'd100);
        pix(10'd170, 1'b1);
        chk("prio_hit",  oHit, 1);
        chk("prio_tile", oTile, 0);
        chk("prio_ovl",  oOverlap, 32'(exp_ovl));
        pix(10'd224, 1'b1);
        chk("moved_hit", oHit, 0);

        // Scan restart
        wr(3'd3, mk(1'b1, 3'd3, 5'd11, 4'd1));
        vs_fall();
        iLineY = 10'd32; iLineStart = 1'b1;
        tick();
        iLineStart = 1'b0;
        repeat (3) tick();
        iLineY = 10'd96; iLineStart = 1'b1;
        tick();
        iLineStart = 1'b0;
        repeat (4) tick();
        chk("restart_busy_e8", oBusy, 1);
        repeat (3) tick();
        chk("restart_busy_e11", oBusy, 1);
        tick();
        chk("restart_busy_e12", oBusy, 0);
        chk("restart_mask", dut.line_mask, 8'b0000_0111);
        pix(10'd352, 1'b1);
        chk("restart_row1_hit", oHit, 0);
        pix(10'd170, 1'b1);
        chk("restart_row3_hit", oHit, 1);
        chk("restart_offy", oOffY, 0);

        // Row 1 directly
        scan(10'd40);
        pix(10'd352, 1'b1);
        chk("row1_hit",  oHit, 1);
        chk("row1_tile", oTile, 3);
        chk("row1_offy", oOffY, 8);

        // Lines with y >= 512 match nothing
        scan(10'd612);
        pix(10'd170, 1'b1);
        chk("y612_hit", oHit, 0);

        // Off-grid x
        scan(10'd100);
        pix(10'd620, 1'b1);
        chk("x620_hit",  oHit, 0);
        chk("x620_offx", oOffX, 12);

        // ON=0 entry on a matching cell
        wr(3'd4, mk(1'b0, 3'd4, 5'd13, 4'd3));
        vs_fall();
        scan(10'd100);
        pix(10'd416, 1'b1);
        chk("off_hit", oHit, 0);

        // Write coinciding with commit lands only in the working table
        iObjRam_addr = 3'd5;
        iObjRam_data = mk(1'b1, 3'd5, 5'd15, 4'd3);
        iObjRam_we   = 1'b1;
        iVS          = 1'b0;
        tick();
        iObjRam_we   = 1'b0;
        iVS          = 1'b1;
        tick();
        scan(10'd100);
        pix(10'd480, 1'b1);
        chk("samecyc_hit", oHit, 0);
        vs_fall();
        scan(10'd100);
        pix(10'd481, 1'b1);
        chk("nextcommit_hit",  oHit, 1);
        chk("nextcommit_tile", oTile, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
